// File: rtl/mult_share_pkg.sv
// Shared types and width helpers for the shared-multiplier scheduler.
// Product is 2*WIDTH bits; the accumulator carries one extra carry bit.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_D = 4;
  localparam int PROD_W  = 2 * WIDTH_D;
  localparam int ACC_W   = 2 * WIDTH_D + 1;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int acc_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/mult_share_sched_core.sv
// Sequential shift-add unsigned multiplier: one add+shift per cycle,
// exactly WIDTH iterations after start, result held until next start.
module seq_mult_core
  import mult_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_D
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product
);

  localparam int AW = acc_w(WIDTH);
  localparam int PW = prod_w(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] breg;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   upper;

  // acc[AW-1] is always zero here, so this equals the carry-kept sum
  assign upper = acc[AW-1:WIDTH]
               + {1'b0, breg & {WIDTH{acc[0]}}};

  assign done    = run && (cnt == CW'(WIDTH - 1));
  assign product = acc[PW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      breg <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      acc  <= {{(WIDTH+1){1'b0}}, a};
      breg <= b;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      acc <= {upper, acc[WIDTH-1:0]} >> 1;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one sequential multiplier among
// NREQ requesters, with a tagged valid/ready result channel.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_D,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [2*WIDTH-1:0]    resp_product,
  output logic                  busy
);

  state_t           state, state_n;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic             any_req;
  logic             accept;
  logic             core_done;
  logic [WIDTH-1:0] a_sel, b_sel;

  // first set req_valid bit at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    any_req  = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req_valid[idx]) begin
        any_req  = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

  assign a_sel = req_a[grant_id*WIDTH +: WIDTH];
  assign b_sel = req_b[grant_id*WIDTH +: WIDTH];

  assign accept = (state == IDLE) && any_req;

  assign req_ready = (accept && !reset)
                   ? (NREQ'(1) << grant_id)
                   : '0;

  assign resp_valid = (state == DONE) && !reset;
  assign busy       = (state != IDLE) && !reset;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (core_done) state_n = DONE;
      DONE:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      resp_id <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        resp_id <= grant_id;
        rr_ptr  <= (grant_id == IDW'(NREQ - 1))
                 ? '0 : grant_id + 1'b1;
      end
    end
  end

  seq_mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .a      (a_sel),
    .b      (b_sel),
    .done   (core_done),
    .product(resp_product)
  );

endmodule
